// File: rtl/volume_octave_arbiter_if.sv
// Handshake and settings bus shared between the volume/octave arbiter and its requesters.
// master: requester/consumer side, slave: arbiter side.
interface volume_octave_arbiter_if;
  logic       kb_valid;
  logic [1:0] kb_op;
  logic       kb_ready;
  logic       btn_valid;
  logic [1:0] btn_op;
  logic       btn_ready;
  logic [2:0] volume;
  logic [2:0] octave;
  logic       changed;
  logic       busy;

  modport master (
    output kb_valid, kb_op, btn_valid, btn_op,
    input  kb_ready, btn_ready, volume, octave, changed, busy
  );

  modport slave (
    input  kb_valid, kb_op, btn_valid, btn_op,
    output kb_ready, btn_ready, volume, octave, changed, busy
  );
endinterface

// File: rtl/volume_octave_arbiter.sv
// Round-robin arbiter applying saturating volume/octave steps from keyboard and button paths.
// Optional mute feature enabled by defining VOLUME_OCTAVE_MUTE_EN.
module volume_octave_arbiter #(
  parameter int          VOL_MIN = 1,
  parameter int          VOL_MAX = 5,
  parameter int          VOL_RST = 3,
  parameter int          OCT_MIN = 1,
  parameter int          OCT_MAX = 3,
  parameter int          OCT_RST = 2,
  parameter logic [15:0] HOLDOFF = 16'd1000
) (
  input  logic clk,
  input  logic rst_n,
  volume_octave_arbiter_if.slave bus
`ifdef VOLUME_OCTAVE_MUTE_EN
  ,
  input  logic mute_toggle,
  output logic muted
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic       GRANT_KB  = 1'b0;
  localparam logic       GRANT_BTN = 1'b1;
  localparam logic [2:0] VMIN = 3'(VOL_MIN);
  localparam logic [2:0] VMAX = 3'(VOL_MAX);
  localparam logic [2:0] VRST = 3'(VOL_RST);
  localparam logic [2:0] OMIN = 3'(OCT_MIN);
  localparam logic [2:0] OMAX = 3'(OCT_MAX);
  localparam logic [2:0] ORST = 3'(OCT_RST);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_op;
  logic        r_last_grant;
  logic [15:0] r_cnt;
  logic [2:0]  r_vol, r_oct;
  logic [2:0]  w_vol_nxt, w_oct_nxt;
  logic        r_changed, r_busy;
  logic        w_kb_ready, w_btn_ready, w_xfer;
  logic [2:0]  w_vol_disp_nxt, w_vol_disp_cur;

  // Ties go to whichever requester was not served last.
  always_comb begin
    w_kb_ready  = 1'b0;
    w_btn_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      w_kb_ready  = bus.kb_valid  && (!bus.btn_valid || (r_last_grant == GRANT_BTN));
      w_btn_ready = bus.btn_valid && (!bus.kb_valid  || (r_last_grant == GRANT_KB));
    end
  end

  assign w_xfer = w_kb_ready || w_btn_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_xfer) w_state_nxt = ST_APPLY;
      ST_APPLY: w_state_nxt = (HOLDOFF != 16'd0) ? ST_HOLD : ST_IDLE;
      ST_HOLD:  if (r_cnt == 16'd0) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_vol_nxt = r_vol;
    w_oct_nxt = r_oct;
    if (r_state == ST_APPLY) begin
      case (r_op)
        2'b00:   if (r_vol > VMIN) w_vol_nxt = r_vol - 3'd1;
        2'b01:   if (r_vol < VMAX) w_vol_nxt = r_vol + 3'd1;
        2'b10:   if (r_oct < OMAX) w_oct_nxt = r_oct + 3'd1;
        default: if (r_oct > OMIN) w_oct_nxt = r_oct - 3'd1;
      endcase
    end
  end

`ifdef VOLUME_OCTAVE_MUTE_EN
  logic       r_muted;
  logic       w_muted_nxt;
  logic [2:0] r_vol_disp;

  // The displayed level is a separate register so muting keeps the stored level intact.
  assign w_muted_nxt    = r_muted ^ mute_toggle;
  assign w_vol_disp_nxt = w_muted_nxt ? '0 : w_vol_nxt;
  assign w_vol_disp_cur = r_vol_disp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_muted    <= 1'b0;
      r_vol_disp <= VRST;
    end else begin
      r_muted    <= w_muted_nxt;
      r_vol_disp <= w_vol_disp_nxt;
    end
  end

  assign muted      = r_muted;
  assign bus.volume = r_vol_disp;
`else
  assign w_vol_disp_nxt = w_vol_nxt;
  assign w_vol_disp_cur = r_vol;
  assign bus.volume     = r_vol;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_last_grant <= GRANT_BTN;
      r_cnt        <= '0;
      r_vol        <= VRST;
      r_oct        <= ORST;
      r_changed    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vol     <= w_vol_nxt;
      r_oct     <= w_oct_nxt;
      r_changed <= (w_vol_disp_nxt != w_vol_disp_cur) || (w_oct_nxt != r_oct);
      r_busy    <= (w_state_nxt != ST_IDLE);
      if (w_xfer) begin
        r_op         <= w_btn_ready ? bus.btn_op : bus.kb_op;
        r_last_grant <= w_btn_ready ? GRANT_BTN : GRANT_KB;
      end
      if ((r_state == ST_APPLY) && (HOLDOFF != 16'd0))
        r_cnt <= HOLDOFF - 16'd1;
      else if ((r_state == ST_HOLD) && (r_cnt != 16'd0))
        r_cnt <= r_cnt - 16'd1;
    end
  end

  assign bus.kb_ready  = w_kb_ready;
  assign bus.btn_ready = w_btn_ready;
  assign bus.octave    = r_oct;
  assign bus.changed   = r_changed;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_volume_octave_arbiter.sv
// Directed bench for volume_octave_arbiter with HOLDOFF=4 (handshake spacing 6 cycles).
module tb_volume_octave_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n_changed;

  volume_octave_arbiter_if bus ();

`ifdef VOLUME_OCTAVE_MUTE_EN
  logic mute_toggle;
  logic muted;
`endif

  volume_octave_arbiter #(
    .VOL_MIN (1),
    .VOL_MAX (5),
    .VOL_RST (3),
    .OCT_MIN (1),
    .OCT_MAX (3),
    .OCT_RST (2),
    .HOLDOFF (16'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef VOLUME_OCTAVE_MUTE_EN
    ,
    .mute_toggle (mute_toggle),
    .muted       (muted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    n_changed     = 0;
    rst_n         = 1'b0;
    bus.kb_valid  = 1'b0;
    bus.kb_op     = 2'b00;
    bus.btn_valid = 1'b0;
    bus.btn_op    = 2'b00;
`ifdef VOLUME_OCTAVE_MUTE_EN
    mute_toggle   = 1'b0;
`endif

    // Reset state
    do_reset();
    check("rst_volume", 16'(bus.volume), 16'd3);
    check("rst_octave", 16'(bus.octave), 16'd2);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_changed", 16'(bus.changed), 16'd0);
    check("rst_kb_ready", 16'(bus.kb_ready), 16'd0);
    check("rst_btn_ready", 16'(bus.btn_ready), 16'd0);

    // Single keyboard vol up with full timing
    bus.kb_valid = 1'b1;
    bus.kb_op    = 2'b01;
    #1;
    check("t2_kb_ready", 16'(bus.kb_ready), 16'd1);
    check("t2_btn_ready", 16'(bus.btn_ready), 16'd0);
    tick();
    bus.kb_valid = 1'b0;
    check("t2_busy_k", 16'(bus.busy), 16'd1);
    check("t2_vol_k", 16'(bus.volume), 16'd3);
    tick();
    check("t2_vol_k1", 16'(bus.volume), 16'd4);
    check("t2_changed_k1", 16'(bus.changed), 16'd1);
    tick();
    check("t2_changed_k2", 16'(bus.changed), 16'd0);
    tick();
    tick();
    check("t2_busy_k4", 16'(bus.busy), 16'd1);
    bus.kb_valid = 1'b1;
    #1;
    check("t2_ready_in_hold", 16'(bus.kb_ready), 16'd0);
    bus.kb_valid = 1'b0;
    tick();
    check("t2_busy_k5", 16'(bus.busy), 16'd0);

    // Simultaneous requests alternate, keyboard first after reset
    do_reset();
    bus.kb_valid  = 1'b1;
    bus.kb_op     = 2'b10;
    bus.btn_valid = 1'b1;
    bus.btn_op    = 2'b00;
    #1;
    check("rr1_kb_ready", 16'(bus.kb_ready), 16'd1);
    check("rr1_btn_ready", 16'(bus.btn_ready), 16'd0);
    tick();
    tick();
    check("rr1_octave", 16'(bus.octave), 16'd3);
    check("rr1_volume", 16'(bus.volume), 16'd3);
    repeat (4) tick();
    check("rr2_kb_ready", 16'(bus.kb_ready), 16'd0);
    check("rr2_btn_ready", 16'(bus.btn_ready), 16'd1);
    tick();
    tick();
    check("rr2_volume", 16'(bus.volume), 16'd2);
    check("rr2_changed", 16'(bus.changed), 16'd1);
    repeat (4) tick();
    check("rr3_kb_ready", 16'(bus.kb_ready), 16'd1);
    check("rr3_btn_ready", 16'(bus.btn_ready), 16'd0);
    tick();
    check("rr3_busy", 16'(bus.busy), 16'd1);
    tick();
    check("rr3_octave_sat", 16'(bus.octave), 16'd3);
    check("rr3_changed_sat", 16'(bus.changed), 16'd0);
    bus.kb_valid  = 1'b0;
    bus.btn_valid = 1'b0;
    repeat (4) tick();

    // Five vol-up steps saturate at 5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.kb_valid = 1'b1;
      bus.kb_op    = 2'b01;
      #1;
      check($sformatf("sat_ready_%0d", i), 16'(bus.kb_ready), 16'd1);
      tick();
      bus.kb_valid = 1'b0;
      tick();
      check($sformatf("sat_vol_%0d", i), 16'(bus.volume), (i == 0) ? 16'd4 : 16'd5);
      if (bus.changed === 1'b1) n_changed++;
      repeat (4) tick();
    end
    check("sat_changed_count", 16'(n_changed), 16'd2);

    // Async reset during HOLD; pending button request served after release
    bus.kb_valid = 1'b1;
    bus.kb_op    = 2'b11;
    #1;
    tick();
    bus.kb_valid = 1'b0;
    tick();
    check("hr_octave_down", 16'(bus.octave), 16'd1);
    tick();
    bus.btn_valid = 1'b1;
    bus.btn_op    = 2'b01;
    #1;
    check("hr_btn_ready_hold", 16'(bus.btn_ready), 16'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("hr_octave_rst", 16'(bus.octave), 16'd2);
    check("hr_volume_rst", 16'(bus.volume), 16'd3);
    check("hr_busy_rst", 16'(bus.busy), 16'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("hr_btn_ready_rel", 16'(bus.btn_ready), 16'd1);
    check("hr_kb_ready_rel", 16'(bus.kb_ready), 16'd0);
    tick();
    bus.btn_valid = 1'b0;
    tick();
    check("hr_btn_vol", 16'(bus.volume), 16'd4);
    check("hr_btn_changed", 16'(bus.changed), 16'd1);
    repeat (4) tick();

`ifdef VOLUME_OCTAVE_MUTE_EN
    // Mute hides volume, stored level keeps moving, unmute restores it
    do_reset();
    mute_toggle = 1'b1;
    tick();
    mute_toggle = 1'b0;
    check("mute_volume", 16'(bus.volume), 16'd0);
    check("mute_flag", 16'(muted), 16'd1);
    for (int i = 0; i < 2; i++) begin
      bus.kb_valid = 1'b1;
      bus.kb_op    = 2'b01;
      #1;
      tick();
      bus.kb_valid = 1'b0;
      tick();
      check($sformatf("mute_vol_%0d", i), 16'(bus.volume), 16'd0);
      check($sformatf("mute_changed_%0d", i), 16'(bus.changed), 16'd0);
      repeat (4) tick();
    end
    mute_toggle = 1'b1;
    tick();
    mute_toggle = 1'b0;
    check("unmute_volume", 16'(bus.volume), 16'd5);
    check("unmute_changed", 16'(bus.changed), 16'd1);
    check("unmute_flag", 16'(muted), 16'd0);
    tick();
    check("unmute_changed_end", 16'(bus.changed), 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
